// File: rtl/eth_tx_arb.sv
// -----------------------------------------------------------------------------
// eth_tx_arb
//
// Transmit arbiter that shares one GMII/MII transmit interface between
// NUM_CH frame-generating protocol channels (ARP, ICMP, UDP, ...).
// A channel raises a one-cycle req; the arbiter latches it as pending, picks a
// winner (round-robin or fixed priority), pulses start to the winner, and then
// forwards only that channel's tx_en/txd until its done pulse (or a stuck-channel
// timeout). A fixed inter-frame gap is enforced before the next grant.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   req         per-channel one-cycle send request pulse
//   start       one-hot one-cycle pulse to the granted channel
//   done        per-channel one-cycle frame-complete pulse
//   ch_tx_en    per-channel transmit enable
//   ch_txd      per-channel data, channel i at [i*DATA_W +: DATA_W]
//   gmii_tx_en  muxed, registered transmit enable
//   gmii_txd    muxed, registered transmit data
//   busy        arbiter not idle
//   grant_id    current or last granted channel
//   pend        pending-request flags
//   timeout     one-cycle pulse when a grant is aborted
// -----------------------------------------------------------------------------
module eth_tx_arb #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 8,
  parameter int IFG_CYC     = 12,
  parameter int TIMEOUT_CYC = 4096,
  parameter int RR_MODE     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req,
  output logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          done,
  input  logic [NUM_CH-1:0]          ch_tx_en,
  input  logic [NUM_CH*DATA_W-1:0]   ch_txd,
  output logic                       gmii_tx_en,
  output logic [DATA_W-1:0]          gmii_txd,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic [NUM_CH-1:0]          pend,
  output logic                       timeout
);

  localparam int GW        = $clog2(NUM_CH);
  localparam int TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int IFG_W     = (IFG_CYC > 2) ? $clog2(IFG_CYC) : 1;
  localparam int IFG_LAST_I = (IFG_CYC > 0) ? IFG_CYC - 1 : 0;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LAST_I);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACTIVE = 2'd2,
    S_IFG    = 2'd3
  } state_t;

  // Where a finished (or aborted) frame goes: skip the gap state entirely
  // when no inter-frame gap is configured.
  localparam state_t END_ST = (IFG_CYC == 0) ? S_IDLE : S_IFG;

  state_t             state_reg, state_next;
  logic [GW-1:0]      grant_reg, grant_next;
  logic               rr_seen_reg, rr_seen_next;
  logic [NUM_CH-1:0]  pend_reg, pend_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [IFG_W-1:0]   ifg_cnt_reg, ifg_cnt_next;
  logic               tx_en_reg;
  logic [DATA_W-1:0]  txd_reg;
  logic               timeout_c;

  logic               win_found;
  logic [GW-1:0]      win_idx;

  logic [DATA_W-1:0]  ch_txd_arr [NUM_CH];

  // ---------------------------------------------------------------------------
  // Per-channel slicing, start decode and pending flags
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_txd_arr[gi] = ch_txd[gi*DATA_W +: DATA_W];

      // start is decoded from the registered grant, so it can never be
      // multi-hot.
      assign start[gi] = (state_reg == S_GRANT) && (grant_reg == GW'(gi));

      // Issuing start clears the flag and absorbs a req arriving in the same
      // cycle: that request is served by the frame being started.
      assign pend_next[gi] = start[gi] ? 1'b0 : (pend_reg[gi] | req[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Winner selection
  // Round-robin searches upward from the channel after the last grant; until
  // the first grant after reset the search begins at channel 0. Fixed
  // priority always searches from channel 0.
  // ---------------------------------------------------------------------------
  always_comb begin : winner_sel
    int base;
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    base      = 0;
    idx       = 0;
    if ((RR_MODE != 0) && rr_seen_reg) begin
      if (int'(grant_reg) + 1 >= NUM_CH) begin
        base = 0;
      end else begin
        base = int'(grant_reg) + 1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = base + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!win_found && pend_reg[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_seen_next = rr_seen_reg;
    to_cnt_next  = to_cnt_reg;
    ifg_cnt_next = ifg_cnt_reg;
    timeout_c    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          grant_next   = win_idx;
          rr_seen_next = 1'b1;
          state_next   = S_GRANT;
        end
      end

      S_GRANT: begin
        to_cnt_next = '0;
        state_next  = S_ACTIVE;
      end

      S_ACTIVE: begin
        // done takes precedence over a timeout landing in the same cycle;
        // done from any other channel is ignored.
        if (done[grant_reg]) begin
          ifg_cnt_next = '0;
          state_next   = END_ST;
        end else if ((TIMEOUT_CYC != 0) && (to_cnt_reg == TO_LAST)) begin
          timeout_c    = 1'b1;
          ifg_cnt_next = '0;
          state_next   = END_ST;
        end else if (TIMEOUT_CYC != 0) begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end

      S_IFG: begin
        if (ifg_cnt_reg == IFG_LAST) begin
          state_next = S_IDLE;
        end else begin
          ifg_cnt_next = ifg_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      grant_reg   <= '0;
      rr_seen_reg <= 1'b0;
      pend_reg    <= '0;
      to_cnt_reg  <= '0;
      ifg_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_seen_reg <= rr_seen_next;
      pend_reg    <= pend_next;
      to_cnt_reg  <= to_cnt_next;
      ifg_cnt_reg <= ifg_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output data mux
  // The gap state stays inside the forwarding window so bytes the channel
  // emits together with or just after its done pulse still reach the PHY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_reg <= 1'b0;
      txd_reg   <= '0;
    end else if (state_reg != S_IDLE) begin
      tx_en_reg <= ch_tx_en[grant_reg];
      txd_reg   <= ch_txd_arr[grant_reg];
    end else begin
      tx_en_reg <= 1'b0;
      txd_reg   <= '0;
    end
  end

  assign gmii_tx_en = tx_en_reg;
  assign gmii_txd   = txd_reg;
  assign busy       = (state_reg != S_IDLE);
  assign grant_id   = grant_reg;
  assign pend       = pend_reg;
  assign timeout    = timeout_c;

endmodule

// File: tb/tb_eth_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arb
//
// Directed bench for eth_tx_arb. Two instances share clock and reset:
//   u_rr : round-robin, IFG 12, timeout 64
//   u_fp : fixed priority, IFG 12, timeout 64
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_eth_tx_arb;

  logic clk;
  logic rst;

  logic [2:0]  rr_req, rr_start, rr_done, rr_ch_tx_en, rr_pend;
  logic [23:0] rr_ch_txd;
  logic        rr_gmii_tx_en, rr_busy, rr_timeout;
  logic [7:0]  rr_gmii_txd;
  logic [1:0]  rr_grant_id;

  logic [2:0]  fp_req, fp_start, fp_done, fp_ch_tx_en, fp_pend;
  logic [23:0] fp_ch_txd;
  logic        fp_gmii_tx_en, fp_busy, fp_timeout;
  logic [7:0]  fp_gmii_txd;
  logic [1:0]  fp_grant_id;

  int tests_run;
  int tests_failed;

  eth_tx_arb #(
    .NUM_CH(3), .DATA_W(8), .IFG_CYC(12), .TIMEOUT_CYC(64), .RR_MODE(1)
  ) u_rr (
    .clk(clk), .rst(rst), .req(rr_req), .start(rr_start), .done(rr_done),
    .ch_tx_en(rr_ch_tx_en), .ch_txd(rr_ch_txd), .gmii_tx_en(rr_gmii_tx_en),
    .gmii_txd(rr_gmii_txd), .busy(rr_busy), .grant_id(rr_grant_id),
    .pend(rr_pend), .timeout(rr_timeout)
  );

  eth_tx_arb #(
    .NUM_CH(3), .DATA_W(8), .IFG_CYC(12), .TIMEOUT_CYC(64), .RR_MODE(0)
  ) u_fp (
    .clk(clk), .rst(rst), .req(fp_req), .start(fp_start), .done(fp_done),
    .ch_tx_en(fp_ch_tx_en), .ch_txd(fp_ch_txd), .gmii_tx_en(fp_gmii_tx_en),
    .gmii_txd(fp_gmii_txd), .busy(fp_busy), .grant_id(fp_grant_id),
    .pend(fp_pend), .timeout(fp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!rr_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain_fp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!fp_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    rr_req = '0; rr_done = '0; rr_ch_tx_en = '0; rr_ch_txd = '0;
    fp_req = '0; fp_done = '0; fp_ch_tx_en = '0; fp_ch_txd = '0;
    repeat (3) tick();
    tests_run++;
    if ({rr_start, rr_gmii_tx_en, rr_gmii_txd, rr_busy, rr_grant_id, rr_pend, rr_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rr: got start=%b en=%b txd=%h busy=%b gid=%0d pend=%b to=%b want all 0",
               rr_start, rr_gmii_tx_en, rr_gmii_txd, rr_busy, rr_grant_id, rr_pend, rr_timeout);
    end
    tests_run++;
    if ({fp_start, fp_gmii_tx_en, fp_gmii_txd, fp_busy, fp_grant_id, fp_pend, fp_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_fp: got start=%b en=%b txd=%h busy=%b gid=%0d pend=%b to=%b want all 0",
               fp_start, fp_gmii_tx_en, fp_gmii_txd, fp_busy, fp_grant_id, fp_pend, fp_timeout);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (rr_busy !== 1'b0 || rr_start !== 3'b000) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got busy=%b start=%b want 0/000", rr_busy, rr_start);
    end
    $display("[TB] reset: outputs idle");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_frame();
    bit ok;
    rr_req = 3'b010;
    tick();
    rr_req = '0;
    tests_run++;
    if (rr_pend !== 3'b010) begin
      tests_failed++;
      $display("FAIL pend_set: got %b want 010", rr_pend);
    end
    tests_run++;
    if (rr_start !== 3'b000) begin
      tests_failed++;
      $display("FAIL early_start: got %b want 000", rr_start);
    end
    tick();
    tests_run++;
    if (rr_start !== 3'b010 || rr_grant_id !== 2'd1 || rr_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_latency: got start=%b gid=%0d busy=%b want 010/1/1",
               rr_start, rr_grant_id, rr_busy);
    end
    tick();
    tests_run++;
    if (rr_pend !== 3'b000) begin
      tests_failed++;
      $display("FAIL pend_clear: got %b want 000", rr_pend);
    end
    for (int k = 0; k < 60; k++) begin
      rr_ch_tx_en = 3'b010;
      rr_ch_txd   = {8'h00, 8'(k), 8'h00};
      rr_done     = (k == 59) ? 3'b010 : 3'b000;
      tick();
      tests_run++;
      if (rr_gmii_tx_en !== 1'b1 || rr_gmii_txd !== 8'(k)) begin
        tests_failed++;
        $display("FAIL frame_byte%0d: got en=%b txd=%h want 1/%h", k, rr_gmii_tx_en, rr_gmii_txd, 8'(k));
      end
    end
    rr_ch_tx_en = '0;
    rr_ch_txd   = '0;
    rr_done     = '0;
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (rr_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL ifg_busy%0d: got %b want 1", i, rr_busy);
      end
      tick();
    end
    tests_run++;
    if (rr_busy !== 1'b0 || rr_gmii_tx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL ifg_end: got busy=%b en=%b want 0/0", rr_busy, rr_gmii_tx_en);
    end
    drain_rr(ok);
    $display("[TB] single_frame: ch1 60 bytes, gap 12");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fixed_priority();
    logic [2:0] prev;
    logic [2:0] seen [2];
    int n;
    bit ok;
    fp_req = 3'b010;
    tick();
    fp_req = '0;
    tick();
    tests_run++;
    if (fp_start !== 3'b010) begin
      tests_failed++;
      $display("FAIL fp_start1: got %b want 010", fp_start);
    end
    tick();
    fp_req = 3'b100;
    tick();
    fp_req = '0;
    tests_run++;
    if (fp_pend !== 3'b100) begin
      tests_failed++;
      $display("FAIL fp_pend2: got %b want 100", fp_pend);
    end
    fp_done = 3'b010;
    tick();
    fp_done = '0;
    tests_run++;
    if (fp_busy !== 1'b1 || fp_start !== 3'b000) begin
      tests_failed++;
      $display("FAIL fp_ifg: got busy=%b start=%b want 1/000", fp_busy, fp_start);
    end
    tick();
    tick();
    fp_req = 3'b001;
    tick();
    fp_req = '0;
    tests_run++;
    if (fp_pend !== 3'b101 || fp_start !== 3'b000) begin
      tests_failed++;
      $display("FAIL fp_pend_ifg: got pend=%b start=%b want 101/000", fp_pend, fp_start);
    end
    n    = 0;
    prev = '0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      tick();
      fp_done = prev;
      prev    = fp_start;
      if (fp_start != 3'b000) begin
        seen[n] = fp_start;
        n++;
      end
    end
    tick();
    fp_done = prev;
    tick();
    fp_done = '0;
    tests_run++;
    if (n != 2) begin
      tests_failed++;
      $display("FAIL fp_start_count: got %0d want 2", n);
    end else begin
      tests_run++;
      if (seen[0] !== 3'b001 || seen[1] !== 3'b100) begin
        tests_failed++;
        $display("FAIL fp_order: got %b,%b want 001,100", seen[0], seen[1]);
      end
    end
    drain_fp(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fp_drain: got busy=%b want 0", fp_busy);
    end
    $display("[TB] fixed_priority: ch0 served before ch2");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rr_rounds();
    logic [2:0] prev;
    logic [2:0] seen [3];
    int         when [3];
    int         n;
    int         cyc;
    bit         ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) begin
      n    = 0;
      prev = '0;
      rr_req = 3'b111;
      tick();
      rr_req = '0;
      cyc = 1;
      for (int i = 0; i < 200 && n < 3; i++) begin
        tick();
        cyc++;
        rr_done = prev;
        prev    = rr_start;
        tests_run++;
        if ($countones(rr_start) > 1) begin
          tests_failed++;
          $display("FAIL start_onehot: got %b want at most one bit", rr_start);
        end
        if (rr_start != 3'b000) begin
          seen[n] = rr_start;
          when[n] = cyc;
          n++;
        end
      end
      tick();
      rr_done = prev;
      tick();
      rr_done = '0;
      tests_run++;
      if (n != 3) begin
        tests_failed++;
        $display("FAIL rr_count_r%0d: got %0d want 3", r, n);
      end
      for (int j = 0; j < n; j++) begin
        tests_run++;
        if (seen[j] !== (3'b001 << j)) begin
          tests_failed++;
          $display("FAIL rr_order_r%0d_%0d: got %b want %b", r, j, seen[j], 3'b001 << j);
        end
        if (j > 0) begin
          tests_run++;
          if (when[j] - when[j-1] != 15) begin
            tests_failed++;
            $display("FAIL rr_spacing_r%0d_%0d: got %0d want 15", r, j, when[j] - when[j-1]);
          end
        end
      end
      if (r == 0 && n > 0) begin
        tests_run++;
        if (when[0] != 2) begin
          tests_failed++;
          $display("FAIL rr_first_latency: got %0d want 2", when[0]);
        end
      end
      drain_rr(ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL rr_drain_r%0d: got busy=%b want 0", r, rr_busy);
      end
      $display("[TB] rr_round %0d: %0d starts", r, n);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    bit ok;
    rr_req = 3'b011;
    tick();
    rr_req = '0;
    tick();
    tests_run++;
    if (rr_start !== 3'b001) begin
      tests_failed++;
      $display("FAIL to_start0: got %b want 001", rr_start);
    end
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 1) begin
        tests_run++;
        if (rr_pend !== 3'b010) begin
          tests_failed++;
          $display("FAIL to_pend1: got %b want 010", rr_pend);
        end
      end
      tests_run++;
      if (rr_timeout !== ((k == 64) ? 1'b1 : 1'b0)) begin
        tests_failed++;
        $display("FAIL to_pulse_at%0d: got %b want %b", k, rr_timeout, (k == 64));
      end
    end
    tick();
    tests_run++;
    if (rr_timeout !== 1'b0 || rr_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_after: got to=%b busy=%b want 0/1", rr_timeout, rr_busy);
    end
    for (int k = 66; k <= 78; k++) begin
      tick();
      if (k == 77) begin
        tests_run++;
        if (rr_busy !== 1'b0 || rr_start !== 3'b000) begin
          tests_failed++;
          $display("FAIL to_idle: got busy=%b start=%b want 0/000", rr_busy, rr_start);
        end
      end
      if (k == 78) begin
        tests_run++;
        if (rr_start !== 3'b010) begin
          tests_failed++;
          $display("FAIL to_next_start: got %b want 010", rr_start);
        end
      end
    end
    tick();
    rr_done = 3'b010;
    tick();
    rr_done = '0;
    drain_rr(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL to_drain: got busy=%b want 0", rr_busy);
    end
    $display("[TB] timeout: ch0 aborted, ch1 served");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_isolation();
    bit ok;
    rr_req = 3'b001;
    tick();
    rr_req = '0;
    tick();
    tests_run++;
    if (rr_start !== 3'b001) begin
      tests_failed++;
      $display("FAIL iso_start: got %b want 001", rr_start);
    end
    for (int k = 0; k < 8; k++) begin
      rr_ch_tx_en = 3'b101;
      rr_ch_txd   = {8'hAA, 8'h00, 8'(8'h10 + k)};
      rr_done     = (k == 7) ? 3'b001 : ((k == 2) ? 3'b100 : 3'b000);
      tick();
      tests_run++;
      if (rr_gmii_tx_en !== 1'b1 || rr_gmii_txd !== 8'(8'h10 + k)) begin
        tests_failed++;
        $display("FAIL iso_byte%0d: got en=%b txd=%h want 1/%h", k, rr_gmii_tx_en, rr_gmii_txd, 8'(8'h10 + k));
      end
    end
    rr_ch_tx_en = 3'b100;
    rr_ch_txd   = {8'hAA, 16'h0000};
    rr_done     = '0;
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (rr_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL iso_busy%0d: got %b want 1", i, rr_busy);
      end
      tick();
      tests_run++;
      if (rr_gmii_tx_en !== 1'b0 || rr_gmii_txd !== 8'h00) begin
        tests_failed++;
        $display("FAIL iso_leak%0d: got en=%b txd=%h want 0/00", i, rr_gmii_tx_en, rr_gmii_txd);
      end
    end
    tests_run++;
    if (rr_busy !== 1'b0 || rr_pend !== 3'b000) begin
      tests_failed++;
      $display("FAIL iso_end: got busy=%b pend=%b want 0/000", rr_busy, rr_pend);
    end
    tick();
    tests_run++;
    if (rr_gmii_tx_en !== 1'b0 || rr_gmii_txd !== 8'h00) begin
      tests_failed++;
      $display("FAIL iso_idle_out: got en=%b txd=%h want 0/00", rr_gmii_tx_en, rr_gmii_txd);
    end
    rr_ch_tx_en = '0;
    rr_ch_txd   = '0;
    drain_rr(ok);
    $display("[TB] isolation: ch2 noise and spurious done blocked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_frame();
    bit ok;
    rr_req = 3'b100;
    tick();
    rr_req = '0;
    tick();
    tests_run++;
    if (rr_start !== 3'b100 || rr_grant_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL rm_start: got start=%b gid=%0d want 100/2", rr_start, rr_grant_id);
    end
    tick();
    rr_req      = 3'b110;
    rr_ch_tx_en = 3'b100;
    rr_ch_txd   = {8'h5A, 16'h0000};
    tick();
    rr_req = '0;
    tests_run++;
    if (rr_pend !== 3'b110 || rr_gmii_tx_en !== 1'b1 || rr_gmii_txd !== 8'h5A || rr_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_pre: got pend=%b en=%b txd=%h busy=%b want 110/1/5a/1",
               rr_pend, rr_gmii_tx_en, rr_gmii_txd, rr_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({rr_start, rr_gmii_tx_en, rr_gmii_txd, rr_busy, rr_grant_id, rr_pend, rr_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL rm_async: got start=%b en=%b txd=%h busy=%b gid=%0d pend=%b to=%b want all 0",
               rr_start, rr_gmii_tx_en, rr_gmii_txd, rr_busy, rr_grant_id, rr_pend, rr_timeout);
    end
    rr_ch_tx_en = '0;
    rr_ch_txd   = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      tests_run++;
      if (rr_start !== 3'b000 || rr_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rm_quiet%0d: got start=%b busy=%b want 000/0", i, rr_start, rr_busy);
      end
    end
    rr_req = 3'b010;
    tick();
    rr_req = '0;
    tick();
    tests_run++;
    if (rr_start !== 3'b010) begin
      tests_failed++;
      $display("FAIL rm_new_req: got %b want 010", rr_start);
    end
    tick();
    rr_done = 3'b010;
    tick();
    rr_done = '0;
    drain_rr(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rm_drain: got busy=%b want 0", rr_busy);
    end
    $display("[TB] reset_mid_frame: pending requests dropped");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_frame();
    test_fixed_priority();
    test_rr_rounds();
    test_timeout();
    test_isolation();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Parametrised successor to the fixed three-way ARP/ICMP/UDP transmit controller.
- Arbitrates NUM_CH frame-generating protocol channels onto one GMII/MII transmit interface.
- Supports round-robin or fixed-priority arbitration, whole-frame grants, an enforced inter-frame gap, and a stuck-channel timeout.
- Sits between the protocol TX engines and the PHY-side transmit path.

Parameters:
NUM_CH, 3, number of transmit channels (2..8)
DATA_W, 8, data width per channel (8 = GMII, 4 = MII)
IFG_CYC, 12, idle cycles forced between frames (0 = none)
TIMEOUT_CYC, 4096, max ACTIVE cycles before abort (0 = disabled)
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_CH  per-channel one-cycle send request pulse
start  out  NUM_CH  one-hot one-cycle pulse telling the granted channel to begin its frame
done  in  NUM_CH  per-channel one-cycle frame-complete pulse
ch_tx_en  in  NUM_CH  per-channel transmit enable
ch_txd  in  NUM_CH*DATA_W  per-channel data; channel i occupies bits [i*DATA_W +: DATA_W]
gmii_tx_en  out  1  muxed, registered transmit enable
gmii_txd  out  DATA_W  muxed, registered transmit data
busy  out  1  arbiter not idle
grant_id  out  $clog2(NUM_CH)  current or last granted channel
pend  out  NUM_CH  pending-request flags
timeout  out  1  one-cycle pulse when a grant is aborted

Behaviour:
- Reset values: start=0, gmii_tx_en=0, gmii_txd=0, busy=0, grant_id=0, pend=0, timeout=0.
- Reset asserted mid-frame returns to IDLE immediately; all pending requests are lost.
- Pending flags:
  - req[i] sets pend[i].
  - Issuing start[i] clears pend[i].
  - If req[i] arrives in the same cycle as start[i], clear wins; that req is merged into the granted frame.
  - A req for a channel that is already pending has no further effect; there is no counting.
- State machine (states: IDLE, GRANT, ACTIVE, IFG):
  - IDLE: if pend is non-zero, select winner w, register grant_id=w, go to GRANT. Otherwise stay.
  - Winner selection, RR_MODE=1: search upward from grant_id+1 modulo NUM_CH. After reset the search starts at index 0.
  - Winner selection, RR_MODE=0: lowest set index wins.
  - GRANT (1 cycle): start[grant_id]=1, go to ACTIVE; the timeout counter clears.
  - ACTIVE:
    - done[grant_id] goes to IFG, or to IDLE if IFG_CYC=0.
    - done from any non-granted channel is ignored.
    - If the counter reaches TIMEOUT_CYC-1 without done: pulse timeout for 1 cycle, then go to IFG/IDLE as for done.
    - If done and timeout would occur in the same cycle, done wins and there is no timeout pulse.
  - IFG: count IFG_CYC cycles, then go to IDLE. Requests arriving during IFG only set pend.
- Minimum spacing: done to the next start is IFG_CYC+2 cycles.
- Data mux:
  - In GRANT, ACTIVE and IFG, gmii_tx_en and gmii_txd are registered from ch_tx_en[grant_id] and ch_txd[grant_id]. Latency is 1 cycle.
  - IFG is included in the mux window so that trailing bytes issued with or after done still pass.
  - In IDLE both outputs are registered 0.
- Non-granted channels' tx_en/txd never reach the output, even if asserted.
- busy = (state != IDLE). start is never multi-hot. grant_id only changes on the IDLE→GRANT transition.

Test Plan:
- NUM_CH=3, RR_MODE=1, IFG_CYC=12: pulse req[1] → start[1] 2 cycles later. Channel drives 60 bytes 0x00..0x3B; gmii_txd matches, delayed 1 cycle. After done[1], busy stays high 12 cycles, then falls.
- Pulse req=3'b111 simultaneously: starts issue in order 0, 1, 2 (after reset). Next req=3'b111 round gives order 0, 1, 2 again. Starts are ≥14 cycles apart.
- RR_MODE=0 with req[2] pending and req[0] arriving during IFG of channel 1: start[0] precedes start[2].
- Granted channel 0 never asserts done, TIMEOUT_CYC=64: timeout pulses 64 cycles after start[0], then the IFG runs; pend[1] is then served normally.
- Non-granted channel 2 drives ch_tx_en=1, txd=0xAA during channel 0's frame: gmii_txd never shows 0xAA. Spurious done[2] is ignored and channel 0's frame completes.
- rst asserted in mid-ACTIVE with pend=3'b110: all outputs 0 asynchronously. After release, no start is issued until a new req arrives.
